// File: rtl/fir_ystream_buffer.sv
// FWFT output buffer behind the FIR Y stream.
// Tracks frame length, checksum and done state.
module fir_ystream_buffer #(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 16,
  parameter int pPTR_W      = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [pDATA_WIDTH-1:0] s_tdata,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  input  logic [31:0]            cfg_len,
  input  logic                   frame_clr,
  output logic [pPTR_W:0]        level,
  output logic                   frame_done,
  output logic                   len_err,
  output logic [pDATA_WIDTH-1:0] frame_sum
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [pPTR_W:0] LP_FULL =
    (pPTR_W+1)'(pDEPTH);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [pDATA_WIDTH:0]   r_mem [pDEPTH];
  logic [pPTR_W-1:0]      r_wr_ptr;
  logic [pPTR_W-1:0]      r_rd_ptr;
  logic [pPTR_W:0]        r_level;
  logic [pPTR_W:0]        w_level_nxt;
  logic [31:0]            r_in_cnt;
  logic [31:0]            r_len_q;
  logic                   r_len_err;
  logic                   r_s_tready;
  logic [pDATA_WIDTH-1:0] r_sum;
  logic [pDATA_WIDTH:0]   r_hold;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_valid;
  logic [pDATA_WIDTH:0]   w_head;
  logic [31:0]            w_cnt1;
  logic [31:0]            w_len;
  logic                   w_bad;

  assign w_valid    = (r_level != '0);
  assign w_wr       = s_tvalid && r_s_tready;
  assign w_rd       = w_valid && m_tready;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_cnt1     = r_in_cnt + 32'd1;
  assign w_len      = (r_state == IDLE) ?
                      cfg_len : r_len_q;
  assign w_bad      = w_wr && (s_tlast ?
                      (w_cnt1 != w_len) :
                      (w_cnt1 == w_len));

  assign s_tready   = r_s_tready;
  assign m_tvalid   = w_valid;
  assign {m_tlast, m_tdata} = w_valid ?
                      w_head : r_hold;
  assign level      = r_level;
  assign frame_done = (r_state == DONE);
  assign len_err    = r_len_err;
  assign frame_sum  = r_sum;

  // Occupancy next value; a clear discards all.
  always_comb begin
    w_level_nxt = r_level;
    if (frame_clr)
      w_level_nxt = '0;
    else if (w_wr && !w_rd)
      w_level_nxt = r_level + 1'b1;
    else if (!w_wr && w_rd)
      w_level_nxt = r_level - 1'b1;
  end

  // Frame FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_wr) w_state_nxt = RUN;
      RUN: begin
        if (w_rd && w_head[pDATA_WIDTH])
          w_state_nxt = DONE;
      end
      DONE: w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
    if (frame_clr) w_state_nxt = IDLE;
  end

  // State, level and registered s_tready.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state    <= IDLE;
      r_level    <= '0;
      r_s_tready <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_level    <= w_level_nxt;
      r_s_tready <= (w_level_nxt != LP_FULL) &&
                    (w_state_nxt != DONE);
    end
  end

  // Storage array holds {tlast, data}.
  always_ff @(posedge axis_clk) begin
    if (w_wr && !frame_clr)
      r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
  end

  // Pointers, beat count, checksum, length flag.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_in_cnt  <= '0;
      r_len_q   <= '0;
      r_len_err <= 1'b0;
      r_sum     <= '0;
      r_hold    <= '0;
    end else if (frame_clr) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_in_cnt  <= '0;
      r_len_err <= 1'b0;
      r_sum     <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_in_cnt <= w_cnt1;
      end
      if (w_wr && r_state == IDLE)
        r_len_q <= cfg_len;
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_sum    <= r_sum + w_head[pDATA_WIDTH-1:0];
        r_hold   <= w_head;
      end
      if (w_bad) r_len_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_ystream_buffer.sv
// Randomized bench for fir_ystream_buffer.
// Queue-based reference model of the frame buffer.
module tb_fir_ystream_buffer;

  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int PW = 4;
  localparam int LW = PW + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tlast = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
  logic [31:0]   cfg_len = '0;
  logic          frame_clr = 1'b0;
  logic [PW:0]   level;
  logic          frame_done;
  logic          len_err;
  logic [DW-1:0] frame_sum;

  always #5 clk = ~clk;

  fir_ystream_buffer #(
    .pDATA_WIDTH(DW),
    .pDEPTH(DEPTH),
    .pPTR_W(PW)
  ) dut (
    .axis_clk(clk),
    .axis_rst_n(rst_n),
    .s_tvalid(s_tvalid),
    .s_tready(s_tready),
    .s_tdata(s_tdata),
    .s_tlast(s_tlast),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tdata(m_tdata),
    .m_tlast(m_tlast),
    .cfg_len(cfg_len),
    .frame_clr(frame_clr),
    .level(level),
    .frame_done(frame_done),
    .len_err(len_err),
    .frame_sum(frame_sum)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [DW:0]   stim[$];
  int            g_i;
  logic [DW:0]   mq[$];
  logic [31:0]   m_cnt;
  logic [31:0]   m_len;
  logic          m_done;
  logic          m_err;
  logic [DW-1:0] m_sum;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear;
    mq.delete();
    m_cnt  = '0;
    m_len  = '0;
    m_done = 1'b0;
    m_err  = 1'b0;
    m_sum  = '0;
  endtask

  task automatic new_frame(input int n, input int tl,
                           input logic [31:0] len,
                           input bit rnd);
    logic [DW-1:0] d;
    stim.delete();
    g_i = 0;
    cfg_len = len;
    for (int k = 1; k <= n; k++) begin
      d = rnd ? DW'($urandom) : DW'(k);
      stim.push_back({1'(k == tl), d});
    end
  endtask

  task automatic do_clr;
    s_tvalid  = 1'b0;
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    model_clear();
    stim.delete();
    g_i = 0;
  endtask

  task automatic run(input int vpct, input int rpct,
                     input int ncyc, input bit must_end,
                     input bit scr);
    int cyc;
    logic acc, rd, exp_rdy, scr_now;
    logic [DW:0] b, hd;
    cyc = 0;
    while (cyc < ncyc &&
           !(g_i >= stim.size() && mq.size() == 0)) begin
      s_tvalid = (g_i < stim.size()) &&
                 ($urandom_range(99) < vpct);
      b = (g_i < stim.size()) ? stim[g_i] : '0;
      s_tlast  = b[DW];
      s_tdata  = b[DW-1:0];
      m_tready = ($urandom_range(99) < rpct);
      exp_rdy  = (mq.size() != DEPTH) && !m_done;
      n_chk++;
      if (s_tready !== exp_rdy) begin
        n_fail++;
        $display("FAIL s_tready: got %b want %b",
                 s_tready, exp_rdy);
      end
      n_chk++;
      if (level !== LW'(mq.size())) begin
        n_fail++;
        $display("FAIL level: got %0d want %0d",
                 level, mq.size());
      end
      n_chk++;
      if (m_tvalid !== (mq.size() != 0)) begin
        n_fail++;
        $display("FAIL m_tvalid: got %b want %b",
                 m_tvalid, mq.size() != 0);
      end
      if (mq.size() != 0) begin
        n_chk++;
        if ({m_tlast, m_tdata} !== mq[0]) begin
          n_fail++;
          $display("FAIL m_beat: got %h want %h",
                   {m_tlast, m_tdata}, mq[0]);
        end
      end
      n_chk++;
      if ({frame_done, len_err} !== {m_done, m_err}) begin
        n_fail++;
        $display("FAIL flags: got %b%b want %b%b",
                 frame_done, len_err, m_done, m_err);
      end
      n_chk++;
      if (frame_sum !== m_sum) begin
        n_fail++;
        $display("FAIL frame_sum: got %h want %h",
                 frame_sum, m_sum);
      end
      acc = s_tvalid && exp_rdy;
      rd  = (mq.size() != 0) && m_tready;
      scr_now = 1'b0;
      if (rd) begin
        hd = mq.pop_front();
        m_sum = m_sum + hd[DW-1:0];
        if (hd[DW]) m_done = 1'b1;
      end
      if (acc) begin
        mq.push_back(b);
        m_cnt = m_cnt + 1;
        if (m_cnt == 1) begin
          m_len = cfg_len;
          scr_now = scr;
        end
        if (b[DW] ? (m_cnt != m_len) : (m_cnt == m_len))
          m_err = 1'b1;
        g_i++;
      end
      tick();
      if (scr_now) cfg_len = $urandom;
      cyc++;
    end
    s_tvalid = 1'b0;
    if (must_end) begin
      n_chk++;
      if (!(g_i >= stim.size() && mq.size() == 0)) begin
        n_fail++;
        $display("FAIL timeout: sent %0d of %0d left %0d",
                 g_i, stim.size(), mq.size());
      end
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s_tready, m_tvalid, m_tlast, frame_done,
         len_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_bits: got %b want 00000",
               {s_tready, m_tvalid, m_tlast,
                frame_done, len_err});
    end
    n_chk++;
    if ({m_tdata, frame_sum, level} !== '0) begin
      n_fail++;
      $display("FAIL rst_vals: got %h %h %0d want 0",
               m_tdata, frame_sum, level);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    model_clear();
    n_chk++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", s_tready);
    end
  endtask

  task automatic test_fill_drain;
    do_clr();
    new_frame(5, 5, 5, 0);
    run(100, 100, 40, 1, 1);
    n_chk++;
    if (frame_sum !== 32'd15) begin
      n_fail++;
      $display("FAIL fd_sum: got %0d want 15", frame_sum);
    end
    n_chk++;
    if ({frame_done, len_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL fd_flags: got %b%b want 10",
               frame_done, len_err);
    end
    n_chk++;
    if ({m_tvalid, m_tlast, m_tdata} !== {2'b01, 32'd5})
    begin
      n_fail++;
      $display("FAIL fd_hold: got %b %b %0d want 0 1 5",
               m_tvalid, m_tlast, m_tdata);
    end
    s_tvalid = 1'b1;
    tick();
    tick();
    n_chk++;
    if ({s_tready, level} !== '0) begin
      n_fail++;
      $display("FAIL fd_stall: got %b %0d want 0 0",
               s_tready, level);
    end
    do_clr();
    n_chk++;
    if (s_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL fd_rearm: got %b want 1", s_tready);
    end
  endtask

  task automatic test_back_pressure;
    do_clr();
    new_frame(20, 20, 20, 0);
    run(100, 0, 20, 0, 0);
    n_chk++;
    if ({s_tready, level} !== {1'b0, LW'(16)}) begin
      n_fail++;
      $display("FAIL bp_full: got %b %0d want 0 16",
               s_tready, level);
    end
    run(100, 100, 100, 1, 0);
    n_chk++;
    if ({level, frame_done, frame_sum} !==
        {LW'(0), 1'b1, 32'd210}) begin
      n_fail++;
      $display("FAIL bp_end: got %0d %b %0d want 0 1 210",
               level, frame_done, frame_sum);
    end
  endtask

  task automatic test_back_to_back;
    do_clr();
    new_frame(18, 18, 18, 1);
    run(100, 0, 8, 0, 0);
    n_chk++;
    if (level !== LW'(8)) begin
      n_fail++;
      $display("FAIL b2b_fill: got %0d want 8", level);
    end
    run(100, 100, 10, 0, 0);
    n_chk++;
    if (level !== LW'(8) || g_i != 18) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d/%0d want 8/18",
               level, g_i);
    end
    run(100, 100, 40, 1, 0);
  endtask

  task automatic test_len_err;
    do_clr();
    new_frame(3, 3, 4, 0);
    run(100, 100, 30, 1, 0);
    n_chk++;
    if ({len_err, frame_done} !== 2'b11) begin
      n_fail++;
      $display("FAIL len_short: got %b%b want 11",
               len_err, frame_done);
    end
    do_clr();
    new_frame(6, 6, 4, 0);
    run(100, 0, 4, 0, 0);
    n_chk++;
    if (len_err !== 1'b1) begin
      n_fail++;
      $display("FAIL len_long4: got %b want 1", len_err);
    end
    run(100, 100, 30, 1, 0);
  endtask

  task automatic test_wrap;
    logic [DW-1:0] sum;
    do_clr();
    stim.delete();
    stim.push_back({1'b0, 32'hFFFF_FFFF});
    stim.push_back({1'b1, 32'h0000_0002});
    g_i = 0;
    cfg_len = 2;
    run(100, 100, 20, 1, 0);
    n_chk++;
    if (frame_sum !== 32'h1) begin
      n_fail++;
      $display("FAIL wrap_sum: got %h want 1", frame_sum);
    end
    do_clr();
    new_frame(600, 600, 600, 1);
    sum = '0;
    foreach (stim[k]) sum = sum + stim[k][DW-1:0];
    run(70, 50, 5000, 1, 0);
    n_chk++;
    if ({frame_done, len_err, frame_sum} !==
        {2'b10, sum}) begin
      n_fail++;
      $display("FAIL wrap600: got %b%b %h want 10 %h",
               frame_done, len_err, frame_sum, sum);
    end
  endtask

  task automatic test_clear;
    do_clr();
    new_frame(10, 10, 10, 1);
    run(100, 0, 7, 0, 0);
    n_chk++;
    if (level !== LW'(7)) begin
      n_fail++;
      $display("FAIL clr_pre: got %0d want 7", level);
    end
    s_tvalid  = 1'b1;
    s_tdata   = 32'hDEAD_BEEF;
    m_tready  = 1'b1;
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
    s_tvalid  = 1'b0;
    model_clear();
    n_chk++;
    if ({level, m_tvalid, frame_done, len_err,
         s_tready, frame_sum} !==
        {LW'(0), 4'b0001, 32'd0}) begin
      n_fail++;
      $display("FAIL clr_post: got %0d %b%b%b%b %h",
               level, m_tvalid, frame_done, len_err,
               s_tready, frame_sum);
    end
    new_frame(3, 3, 3, 0);
    run(100, 100, 30, 1, 0);
    n_chk++;
    if ({frame_done, len_err, frame_sum} !==
        {2'b10, 32'd6}) begin
      n_fail++;
      $display("FAIL clr_next: got %b%b %0d want 10 6",
               frame_done, len_err, frame_sum);
    end
  endtask

  task automatic test_reset_mid;
    do_clr();
    new_frame(8, 8, 8, 1);
    run(100, 30, 5, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s_tready, m_tvalid, m_tlast, frame_done,
         len_err, level, m_tdata, frame_sum} !== '0)
    begin
      n_fail++;
      $display("FAIL rst_mid: got %b%b%b%b%b %0d %h %h",
               s_tready, m_tvalid, m_tlast, frame_done,
               len_err, level, m_tdata, frame_sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    model_clear();
    n_chk++;
    if ({s_tready, level} !== {1'b1, LW'(0)}) begin
      n_fail++;
      $display("FAIL rst_rearm: got %b %0d want 1 0",
               s_tready, level);
    end
    new_frame(3, 3, 3, 0);
    run(100, 100, 30, 1, 0);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill_drain();
    test_back_pressure();
    test_back_to_back();
    test_len_err();
    test_wrap();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
